// File: rtl/ula_exec_ctrl.sv
// Execute-stage controller for Ula4bits: fetches operands from a small register bank,
// drives the combinational ALU, captures its flags, then writes back or signals a branch.
module ula_exec_ctrl #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned NREG  = 4,
    localparam int unsigned AW   = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic             in_cmp,
    input  logic [AW-1:0]    in_rd,
    input  logic [AW-1:0]    in_rs,
    input  logic [AW-1:0]    in_rt,
    input  logic             load_en,
    input  logic [AW-1:0]    load_addr,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] ula_a,
    output logic [WIDTH-1:0] ula_b,
    output logic             ula_x0,
    output logic             ula_x1,
    output logic             ula_x2,
    input  logic [WIDTH-1:0] ula_f,
    input  logic [WIDTH-1:0] ula_menor,
    input  logic [WIDTH-1:0] ula_igual,
    output logic             done,
    output logic             br_taken,
    output logic             flag_lt,
    input  logic [AW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    typedef enum logic [1:0] {StIdle, StRead, StExec, StWb} state_e;

    state_e            r_state;
    state_e            w_state_d;
    logic              w_accept;

    logic [2:0]        r_op;
    logic              r_cmp;
    logic [AW-1:0]     r_rd;
    logic [AW-1:0]     r_rs;
    logic [AW-1:0]     r_rt;
    logic [WIDTH-1:0]  r_res;
    logic              r_eq;
    logic              r_lt;
    logic              r_flag_lt;
    logic [WIDTH-1:0]  r_ula_a;
    logic [WIDTH-1:0]  r_ula_b;
    logic [2:0]        r_ula_x;
    logic [WIDTH-1:0]  r_bank [NREG];

    // Next-state logic and handshake / retire outputs
    always_comb begin
        w_state_d = r_state;
        w_accept  = 1'b0;
        in_ready  = (r_state == StIdle) && !load_en && !rst;
        done      = 1'b0;
        br_taken  = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (in_valid && in_ready) begin
                    w_accept  = 1'b1;
                    w_state_d = StRead;
                end
            end
            StRead: w_state_d = StExec;
            StExec: w_state_d = StWb;
            StWb: begin
                // Retire pulse is masked while reset is asserted so an abort never retires
                done      = !rst;
                br_taken  = !rst && r_cmp && r_eq;
                w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Instruction latch, ALU drive registers and result/flag capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op      <= '0;
            r_cmp     <= 1'b0;
            r_rd      <= '0;
            r_rs      <= '0;
            r_rt      <= '0;
            r_res     <= '0;
            r_eq      <= 1'b0;
            r_lt      <= 1'b0;
            r_flag_lt <= 1'b0;
            r_ula_a   <= '0;
            r_ula_b   <= '0;
            r_ula_x   <= '0;
        end else begin
            if (w_accept) begin
                r_op  <= in_op;
                r_cmp <= in_cmp;
                r_rd  <= in_rd;
                r_rs  <= in_rs;
                r_rt  <= in_rt;
            end
            // ALU inputs only change here, so the ALU sees stable operands otherwise
            if (r_state == StRead) begin
                r_ula_a <= r_bank[r_rs];
                r_ula_b <= r_bank[r_rt];
                r_ula_x <= r_op;
            end
            if (r_state == StExec) begin
                r_res <= ula_f;
                r_eq  <= |ula_igual;
                r_lt  <= |ula_menor;
            end
            if (r_state == StWb) begin
                r_flag_lt <= r_lt;
            end
        end
    end

    // Register bank: preload in IDLE has priority, writeback in WB for non-compare ops
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_bank[i] <= '0;
            end
        end else if ((r_state == StIdle) && load_en) begin
            r_bank[load_addr] <= load_data;
        end else if ((r_state == StWb) && !r_cmp) begin
            r_bank[r_rd] <= r_res;
        end
    end

    assign ula_a    = r_ula_a;
    assign ula_b    = r_ula_b;
    assign ula_x0   = r_ula_x[0];
    assign ula_x1   = r_ula_x[1];
    assign ula_x2   = r_ula_x[2];
    assign flag_lt  = r_flag_lt;
    assign dbg_data = r_bank[dbg_addr];

endmodule
